// File: rtl/c1s2_fmap_loader.sv
// Streams one feature map into the five replicated C1S2 data buffers via a broadcast write
// port, then runs the C1S2 layer until it reports work finished.
module c1s2_fmap_loader #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_WORDS = 6144,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_din,
    output logic              layer_en,
    input  logic              layer_done,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_FIN
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_e              state_q, state_d;
    logic                buf_we_q, buf_we_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_din_q, buf_din_d;
    logic                layer_en_q, layer_en_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;

    // State and registered bus; reset drops any write already staged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
            layer_en_q <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
            layer_en_q <= layer_en_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;
        layer_en_d = 1'b0;
        done_d     = 1'b0;
        word_cnt_d = word_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = BASE + word_cnt_q;
                    buf_din_d  = in_data;
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    if (word_cnt_q == LAST_IDX) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            // Final write lands this cycle; the layer starts reading only after it.
            S_SETTLE: begin
                state_d    = S_RUN;
                layer_en_d = 1'b1;
            end
            S_RUN: begin
                if (layer_done) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    layer_en_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_din  = buf_din_q;
    assign layer_en = layer_en_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_c1s2_fmap_loader.sv
// Directed and randomized checks of c1s2_fmap_loader on three configurations:
// full 6144-word map, 64-word map with bubbles, and a single word at base 100.
module tb_c1s2_fmap_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Full-size instance
    logic        f_rst, f_start, f_in_valid, f_in_ready, f_buf_we, f_layer_en, f_layer_done, f_busy, f_done;
    logic [15:0] f_in_data, f_buf_din;
    logic [31:0] f_buf_addr, f_word_cnt;
    // 64-word instance
    logic        s_rst, s_start, s_in_valid, s_in_ready, s_buf_we, s_layer_en, s_layer_done, s_busy, s_done;
    logic [15:0] s_in_data, s_buf_din;
    logic [31:0] s_buf_addr, s_word_cnt;
    // Single-word instance at base 100
    logic        o_rst, o_start, o_in_valid, o_in_ready, o_buf_we, o_layer_en, o_layer_done, o_busy, o_done;
    logic [15:0] o_in_data, o_buf_din;
    logic [31:0] o_buf_addr, o_word_cnt;

    c1s2_fmap_loader #(.DATA_W(16), .ADDR_W(32), .NUM_WORDS(6144), .BASE_ADDR(0)) u_full (
        .clk(clk), .rst(f_rst), .start(f_start), .in_valid(f_in_valid), .in_data(f_in_data),
        .in_ready(f_in_ready), .buf_we(f_buf_we), .buf_addr(f_buf_addr), .buf_din(f_buf_din),
        .layer_en(f_layer_en), .layer_done(f_layer_done), .busy(f_busy), .done(f_done),
        .word_cnt(f_word_cnt));

    c1s2_fmap_loader #(.DATA_W(16), .ADDR_W(32), .NUM_WORDS(64), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .buf_we(s_buf_we), .buf_addr(s_buf_addr), .buf_din(s_buf_din),
        .layer_en(s_layer_en), .layer_done(s_layer_done), .busy(s_busy), .done(s_done),
        .word_cnt(s_word_cnt));

    c1s2_fmap_loader #(.DATA_W(16), .ADDR_W(32), .NUM_WORDS(1), .BASE_ADDR(100)) u_one (
        .clk(clk), .rst(o_rst), .start(o_start), .in_valid(o_in_valid), .in_data(o_in_data),
        .in_ready(o_in_ready), .buf_we(o_buf_we), .buf_addr(o_buf_addr), .buf_din(o_buf_din),
        .layer_en(o_layer_en), .layer_done(o_layer_done), .busy(o_busy), .done(o_done),
        .word_cnt(o_word_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All outputs must be at their reset/idle values.
    task automatic chk_idle(input string tag, input logic ir, input logic we, input logic le,
                            input logic dn, input logic bs, input logic [31:0] addr,
                            input logic [15:0] din, input logic [31:0] wc);
        chk({tag, ".in_ready"}, 64'(ir), 64'd0);
        chk({tag, ".buf_we"},   64'(we), 64'd0);
        chk({tag, ".layer_en"}, 64'(le), 64'd0);
        chk({tag, ".done"},     64'(dn), 64'd0);
        chk({tag, ".busy"},     64'(bs), 64'd0);
        chk({tag, ".buf_addr"}, 64'(addr), 64'd0);
        chk({tag, ".buf_din"},  64'(din), 64'd0);
        chk({tag, ".word_cnt"}, 64'(wc), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] dq[$];
        logic [15:0] d;
        int          n;
        int          cyc;
        int          wr_seen;
        logic        acc;

        {f_rst, s_rst, o_rst} = 3'b111;
        {f_start, f_in_valid, f_layer_done} = 3'b000;
        {s_start, s_in_valid, s_layer_done} = 3'b000;
        {o_start, o_in_valid, o_layer_done} = 3'b000;
        f_in_data = '0; s_in_data = '0; o_in_data = '0;
        tick();
        tick();
        chk_idle("rst_full", f_in_ready, f_buf_we, f_layer_en, f_done, f_busy, f_buf_addr, f_buf_din, f_word_cnt);
        chk_idle("rst_small", s_in_ready, s_buf_we, s_layer_en, s_done, s_busy, s_buf_addr, s_buf_din, s_word_cnt);
        chk_idle("rst_one", o_in_ready, o_buf_we, o_layer_en, o_done, o_busy, o_buf_addr, o_buf_din, o_word_cnt);
        {f_rst, s_rst, o_rst} = 3'b000;
        tick();

        // Reset in the middle of a load, after 100 words
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        chk("abort.in_ready", 64'(f_in_ready), 64'd1);
        for (int i = 0; i < 100; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 16'($urandom);
            d = f_in_data;
            tick();
            chk("abort.we", 64'(f_buf_we), 64'd1);
            chk("abort.addr", 64'(f_buf_addr), 64'(i));
            chk("abort.din", 64'(f_buf_din), 64'(d));
        end
        f_rst = 1'b1;
        tick();
        chk_idle("abort_rst", f_in_ready, f_buf_we, f_layer_en, f_done, f_busy, f_buf_addr, f_buf_din, f_word_cnt);
        tick();
        f_start = 1'b1;
        tick();
        chk_idle("rst_vs_start", f_in_ready, f_buf_we, f_layer_en, f_done, f_busy, f_buf_addr, f_buf_din, f_word_cnt);
        f_rst = 1'b0; f_start = 1'b0; f_in_valid = 1'b0;
        tick();
        chk("post_rst.busy", 64'(f_busy), 64'd0);

        // Full streaming load, data = index + 10000
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        chk("full.busy", 64'(f_busy), 64'd1);
        chk("full.wc0", 64'(f_word_cnt), 64'd0);
        for (int i = 0; i < 6144; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 16'(i + 10000);
            chk("full.in_ready", 64'(f_in_ready), 64'd1);
            tick();
            chk("full.we", 64'(f_buf_we), 64'd1);
            chk("full.addr", 64'(f_buf_addr), 64'(i));
            chk("full.din", 64'(f_buf_din), 64'(i + 10000));
            chk("full.wc", 64'(f_word_cnt), 64'(i + 1));
        end
        f_in_data = 16'hDEAD;
        chk("settle.in_ready", 64'(f_in_ready), 64'd0);
        chk("settle.layer_en", 64'(f_layer_en), 64'd0);
        tick();
        chk("run.we", 64'(f_buf_we), 64'd0);
        chk("run.layer_en", 64'(f_layer_en), 64'd1);
        chk("run.in_ready", 64'(f_in_ready), 64'd0);
        chk("run.wc", 64'(f_word_cnt), 64'd6144);
        f_in_valid = 1'b0;

        // Layer handshake: long wait, then done
        for (int i = 0; i < 500; i++) begin
            tick();
            chk("wait.layer_en", 64'(f_layer_en), 64'd1);
            chk("wait.done", 64'(f_done), 64'd0);
        end
        f_layer_done = 1'b1;
        tick();
        chk("fin.layer_en", 64'(f_layer_en), 64'd0);
        chk("fin.done", 64'(f_done), 64'd1);
        chk("fin.busy", 64'(f_busy), 64'd1);
        f_layer_done = 1'b0;
        tick();
        chk("idle.done", 64'(f_done), 64'd0);
        chk("idle.busy", 64'(f_busy), 64'd0);
        chk("idle.wc_hold", 64'(f_word_cnt), 64'd6144);
        f_layer_done = 1'b1;
        tick();
        chk("idle_ld.done", 64'(f_done), 64'd0);
        chk("idle_ld.layer_en", 64'(f_layer_en), 64'd0);
        chk("idle_ld.busy", 64'(f_busy), 64'd0);
        f_layer_done = 1'b0;

        // Bubbled 64-word load with start pulses while busy
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        n = 0; cyc = 0; wr_seen = 0;
        dq.delete();
        while (n < 64 && cyc < 2000) begin
            s_in_valid = 1'($urandom % 2);
            s_in_data  = 16'($urandom);
            s_start    = (cyc == 10 || cyc == 20);
            acc = s_in_valid;
            if (acc) dq.push_back(s_in_data);
            chk("bub.in_ready", 64'(s_in_ready), 64'd1);
            tick();
            wr_seen += int'(s_buf_we);
            if (acc) begin
                chk("bub.we", 64'(s_buf_we), 64'd1);
                chk("bub.addr", 64'(s_buf_addr), 64'(n));
                chk("bub.din", 64'(s_buf_din), 64'(dq.pop_front()));
                n++;
            end else begin
                chk("bub.we_idle", 64'(s_buf_we), 64'd0);
            end
            chk("bub.wc", 64'(s_word_cnt), 64'(n));
            cyc++;
        end
        chk("bub.words_loaded", 64'(n), 64'd64);
        s_start = 1'b0;
        s_in_valid = 1'b1;
        chk("bub.settle_ready", 64'(s_in_ready), 64'd0);
        tick();
        wr_seen += int'(s_buf_we);
        chk("bub.layer_en", 64'(s_layer_en), 64'd1);
        s_start = 1'b1;
        tick();
        wr_seen += int'(s_buf_we);
        s_start = 1'b0;
        chk("bub.run_start.wc", 64'(s_word_cnt), 64'd64);
        chk("bub.run_start.layer_en", 64'(s_layer_en), 64'd1);
        chk("bub.run_start.busy", 64'(s_busy), 64'd1);
        chk("bub.we_total", 64'(wr_seen), 64'd64);
        s_layer_done = 1'b1;
        tick();
        chk("bub.done", 64'(s_done), 64'd1);
        s_layer_done = 1'b0;
        s_in_valid = 1'b0;
        tick();
        chk("bub.idle_busy", 64'(s_busy), 64'd0);
        chk("bub.wc_hold", 64'(s_word_cnt), 64'd64);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("bub.restart_wc", 64'(s_word_cnt), 64'd0);

        // Single-word load at base 100
        o_start = 1'b1;
        tick();
        o_start = 1'b0;
        chk("one.in_ready", 64'(o_in_ready), 64'd1);
        o_in_valid = 1'b1;
        o_in_data  = 16'($urandom);
        d = o_in_data;
        tick();
        chk("one.we", 64'(o_buf_we), 64'd1);
        chk("one.addr", 64'(o_buf_addr), 64'd100);
        chk("one.din", 64'(o_buf_din), 64'(d));
        chk("one.settle_ready", 64'(o_in_ready), 64'd0);
        chk("one.wc", 64'(o_word_cnt), 64'd1);
        chk("one.settle_en", 64'(o_layer_en), 64'd0);
        tick();
        chk("one.run_we", 64'(o_buf_we), 64'd0);
        chk("one.run_en", 64'(o_layer_en), 64'd1);
        chk("one.run_ready", 64'(o_in_ready), 64'd0);
        o_in_valid = 1'b0;
        o_layer_done = 1'b1;
        tick();
        chk("one.done", 64'(o_done), 64'd1);
        o_layer_done = 1'b0;
        tick();
        chk("one.idle_busy", 64'(o_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
